// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared encodings for the unified-memory port arbiter: FSM states, owner
//   encodings and the width of the latency / starvation counters.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Owner of the outstanding access.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Width of lat_cnt and starve_cnt (covers the 1..15 parameter range).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner selection between the fetch and data ports.
//   Default build: data wins a conflict unless starve_cnt has reached
//   STARVE_LIMIT. With ARB_ROUND_ROBIN_EN defined: a conflict goes to the
//   port opposite last_owner.
// Ports
//   if_req      in   fetch request
//   d_req       in   data request
//   starve_cnt  in   consecutive fetch conflict losses (default build only)
//   last_owner  in   owner of the previous access (ARB_ROUND_ROBIN_EN only)
//   pick_if     out  fetch selected
//   pick_d      out  data selected
// ----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic             if_req,
    input  logic             d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic             last_owner,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             pick_if,
    output logic             pick_d
);

    logic if_pref;   // fetch wins if both ports request

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if_pref = (last_owner == OWN_D);
`else
        if_pref = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif
        pick_if = if_req & (~d_req | if_pref);
        pick_d  = d_req & ~pick_if;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port and the load/store data port. One access is outstanding at a time;
//   the response arrives MEM_LATENCY cycles after the grant and is routed
//   back to the port that won. cpu_stall is raised while either port waits.
//   Optional macro ARB_ROUND_ROBIN_EN selects round-robin conflict
//   resolution instead of data priority with a fetch starvation limit.
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request and address
//   if_gnt/if_rvalid/if_rdata       fetch grant, response strobe, data
//   d_req/d_we/d_addr/d_wdata       data request, store flag, address, data
//   d_gnt/d_rvalid/d_rdata          data grant, response strobe, load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory access strobe and command
//   mem_rdata                       memory read data (MEM_LATENCY after mem_en)
//   cpu_stall                       pipeline hold
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_stall
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic                  owner_q;      // also serves as last_owner
    logic                  we_q;         // outstanding access is a store
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  pick_if, pick_d;
    logic                  arb_en, grant, resp;

`ifndef ARB_ROUND_ROBIN_EN
    logic [CNT_W-1:0]      starve_cnt_q;
`endif

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_owner (owner_q),
`else
        .starve_cnt (starve_cnt_q),
`endif
        .pick_if    (pick_if),
        .pick_d     (pick_d)
    );

    // NOTE: the grant path is combinational from the request inputs, so it is
    // gated by reset as well; otherwise a request held during reset would
    // leak through to if_gnt/d_gnt/mem_en/cpu_stall.
    assign arb_en = reset & (state_q == IDLE);
    assign if_gnt = arb_en & pick_if;
    assign d_gnt  = arb_en & pick_d;
    assign grant  = if_gnt | d_gnt;

    assign resp      = (state_q == WAIT) & (lat_cnt_q == CNT_W'(MEM_LATENCY));
    assign if_rvalid = resp & (owner_q == OWN_IF);
    assign d_rvalid  = resp & (owner_q == OWN_D);

    // Response data is visible in the rvalid cycle and held afterwards.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = (d_rvalid & ~we_q) ? mem_rdata : d_rdata_q;

    assign mem_en    = grant;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = (d_gnt & d_we) ? d_wdata : '0;

    assign cpu_stall = reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt) |
                                ((state_q == WAIT) & ~(if_rvalid | d_rvalid)));

    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = WAIT;
                    lat_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (resp) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            if (grant) begin
                owner_q <= d_gnt ? OWN_D : OWN_IF;
                we_q    <= d_gnt & d_we;
            end
            if (if_rvalid)
                if_rdata_q <= mem_rdata;
            if (d_rvalid & ~we_q)
                d_rdata_q <= mem_rdata;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Counts consecutive conflicts lost by fetch; saturates at the counter max.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else if (if_gnt) begin
            starve_cnt_q <= '0;
        end else if (d_gnt & if_req & (starve_cnt_q != {CNT_W{1'b1}})) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=2,
//   STARVE_LIMIT=3). Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_stall (cpu_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle's drive point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".if_gnt"},    {63'd0, if_gnt},    64'd0);
        check({tag, ".if_rvalid"}, {63'd0, if_rvalid}, 64'd0);
        check({tag, ".if_rdata"},  if_rdata,           64'd0);
        check({tag, ".d_gnt"},     {63'd0, d_gnt},     64'd0);
        check({tag, ".d_rvalid"},  {63'd0, d_rvalid},  64'd0);
        check({tag, ".d_rdata"},   d_rdata,            64'd0);
        check({tag, ".mem_en"},    {63'd0, mem_en},    64'd0);
        check({tag, ".mem_we"},    {63'd0, mem_we},    64'd0);
        check({tag, ".mem_addr"},  mem_addr,           64'd0);
        check({tag, ".mem_wdata"}, mem_wdata,          64'd0);
        check({tag, ".cpu_stall"}, {63'd0, cpu_stall}, 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;

        // 1. Reset held three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if_req    = 1'($urandom);
            if_addr   = {$urandom, $urandom};
            d_req     = 1'($urandom);
            d_we      = 1'($urandom);
            d_addr    = {$urandom, $urandom};
            d_wdata   = {$urandom, $urandom};
            mem_rdata = {$urandom, $urandom};
            sample();
            check_all_zero($sformatf("rst%0d", i));
        end
        next_cycle();
        reset  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        mem_rdata = '0;
        sample();
        check("rel.cpu_stall", {63'd0, cpu_stall}, 64'd0);
        check("rel.mem_en",    {63'd0, mem_en},    64'd0);

        // 2. Single fetch.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 64'h100;
        sample();
        check("f.if_gnt",   {63'd0, if_gnt}, 64'd1);
        check("f.d_gnt",    {63'd0, d_gnt},  64'd0);
        check("f.mem_en",   {63'd0, mem_en}, 64'd1);
        check("f.mem_we",   {63'd0, mem_we}, 64'd0);
        check("f.mem_addr", mem_addr,        64'h100);
        next_cycle();
        if_req = 1'b0;
        sample();
        check("f1.if_rvalid", {63'd0, if_rvalid}, 64'd0);
        check("f1.cpu_stall", {63'd0, cpu_stall}, 64'd1);
        check("f1.mem_en",    {63'd0, mem_en},    64'd0);
        next_cycle();
        mem_rdata = 64'hDEADBEEF;
        sample();
        check("f2.if_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("f2.if_rdata",  if_rdata,           64'hDEADBEEF);
        check("f2.d_rvalid",  {63'd0, d_rvalid},  64'd0);
        check("f2.cpu_stall", {63'd0, cpu_stall}, 64'd0);
        next_cycle();
        mem_rdata = '0;
        sample();
        check("f3.if_rvalid", {63'd0, if_rvalid}, 64'd0);
        check("f3.d_rvalid",  {63'd0, d_rvalid},  64'd0);
        check("f3.if_rdata",  if_rdata,           64'hDEADBEEF);

        // 3. Simultaneous fetch and load: data wins, fetch follows.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 64'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h300;
        sample();
        check("c0.d_gnt",     {63'd0, d_gnt},     64'd1);
        check("c0.if_gnt",    {63'd0, if_gnt},    64'd0);
        check("c0.mem_addr",  mem_addr,           64'h300);
        check("c0.cpu_stall", {63'd0, cpu_stall}, 64'd1);
        next_cycle();
        d_req = 1'b0;
        sample();
        check("c1.cpu_stall", {63'd0, cpu_stall}, 64'd1);
        check("c1.if_gnt",    {63'd0, if_gnt},    64'd0);
        next_cycle();
        mem_rdata = 64'hAAAA;
        sample();
        check("c2.d_rvalid",  {63'd0, d_rvalid},  64'd1);
        check("c2.d_rdata",   d_rdata,            64'hAAAA);
        check("c2.if_gnt",    {63'd0, if_gnt},    64'd0);
        check("c2.cpu_stall", {63'd0, cpu_stall}, 64'd1);
        next_cycle();
        mem_rdata = '0;
        sample();
        check("c3.if_gnt",   {63'd0, if_gnt}, 64'd1);
        check("c3.mem_addr", mem_addr,        64'h200);
        check("c3.d_rdata",  d_rdata,         64'hAAAA);
        next_cycle();
        if_req = 1'b0;
        sample();
        check("c4.cpu_stall", {63'd0, cpu_stall}, 64'd1);
        next_cycle();
        mem_rdata = 64'h1111;
        sample();
        check("c5.if_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("c5.if_rdata",  if_rdata,           64'h1111);
        check("c5.cpu_stall", {63'd0, cpu_stall}, 64'd0);
        next_cycle();
        mem_rdata = '0;

        // 4. Both ports held: starvation limit (or alternation with round robin).
        next_cycle();
        mem_rdata = 64'h77;
        if_req  = 1'b1;
        if_addr = 64'h400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h480;
        for (int i = 0; i < 10; i++) begin
            logic exp_if, exp_d;
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (i == 3) || (i == 9);
            exp_d  = (i == 0) || (i == 6);
`else
            exp_if = (i == 9);
            exp_d  = (i == 0) || (i == 3) || (i == 6);
`endif
            sample();
            check($sformatf("s%0d.if_gnt", i), {63'd0, if_gnt}, {63'd0, exp_if});
            check($sformatf("s%0d.d_gnt", i),  {63'd0, d_gnt},  {63'd0, exp_d});
            next_cycle();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        sample();
        next_cycle();
        sample();
        check("s11.if_rvalid", {63'd0, if_rvalid}, 64'd1);
        next_cycle();
        mem_rdata = '0;

        // 5. Store: d_rdata keeps the last load value.
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h40;
        d_wdata = 64'h1234;
        sample();
        check("st0.d_gnt",     {63'd0, d_gnt},  64'd1);
        check("st0.mem_en",    {63'd0, mem_en}, 64'd1);
        check("st0.mem_we",    {63'd0, mem_we}, 64'd1);
        check("st0.mem_addr",  mem_addr,        64'h40);
        check("st0.mem_wdata", mem_wdata,       64'h1234);
        next_cycle();
        d_req = 1'b0;
        d_we  = 1'b0;
        next_cycle();
        mem_rdata = 64'h9999;
        sample();
        check("st2.d_rvalid",  {63'd0, d_rvalid},  64'd1);
        check("st2.d_rdata",   d_rdata,            64'h77);
        check("st2.if_rvalid", {63'd0, if_rvalid}, 64'd0);
        next_cycle();
        mem_rdata = '0;

        // 6. Reset pulsed during WAIT abandons the fetch.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 64'h500;
        sample();
        check("r0.if_gnt", {63'd0, if_gnt}, 64'd1);
        next_cycle();
        if_req = 1'b0;
        reset  = 1'b0;
        sample();
        check("r1.if_rvalid", {63'd0, if_rvalid}, 64'd0);
        next_cycle();
        reset     = 1'b1;
        mem_rdata = 64'hBAD;
        sample();
        check("r2.if_rvalid", {63'd0, if_rvalid}, 64'd0);
        check("r2.cpu_stall", {63'd0, cpu_stall}, 64'd0);
        next_cycle();
        mem_rdata = '0;
        if_req    = 1'b1;
        if_addr   = 64'h508;
        sample();
        check("r3.if_gnt",   {63'd0, if_gnt}, 64'd1);
        check("r3.mem_addr", mem_addr,        64'h508);
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        mem_rdata = 64'hC0DE;
        sample();
        check("r5.if_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("r5.if_rdata",  if_rdata,           64'hC0DE);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
